seq_detector_param: RTL and testbench

Parametrised serial bit-pattern detector, successor to the fixed 4-bit Mealy detector.
- Pattern and don't-care mask are runtime-loadable.
- Overlapping or non-overlapping match mode is selectable.
- Z is a registered one-cycle match pulse; an optional saturating match counter is available.
- Sits on a serial input line, clocked by the system clock, feeding control/status logic.

---
 rtl/seq_detector_param.sv | 149 ++++++++++++++
 tb/tb_seq_detector_param.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_detector_param.sv
// seq_detector_param
// Serial bit-pattern detector with a runtime-loadable pattern and care mask.
// Incoming bits (qualified by en) shift into a PAT_W-bit history; once PAT_W
// bits have been collected the history is compared against the pattern under
// the care mask, and a match raises Z for exactly one cycle.
// Overlapping matches keep the history; non-overlapping matches restart the fill.
//
// Handshake: there is no backpressure. A bit is consumed on every rising CLK
// edge where en=1 and load=0. load=1 takes priority and discards the history.
//
// Optional feature macro: MATCH_CNT_EN adds a saturating match counter on
// match_count, cleared by clr_count. When the macro is not defined,
// match_count is tied to zero and clr_count is ignored.
//
// state_o exposes the FSM state (EMPTY=0, FILLING=1, ARMED=2) for debug.
module seq_detector_param #(
   parameter int                 PAT_W     = 4,
   parameter logic [PAT_W-1:0]   PAT_RESET = 4'b1101,
   parameter int                 CNT_W     = 8
) (
   input  logic              CLK,
   input  logic              RESET_N,
   input  logic              en,
   input  logic              x,
   input  logic              load,
   input  logic [PAT_W-1:0]  pat_in,
   input  logic [PAT_W-1:0]  care_in,
   input  logic              overlap,
   input  logic              clr_count,
   output logic              Z,
   output logic [CNT_W-1:0]  match_count,
   output logic [1:0]        state_o
);

   localparam int FW = $clog2(PAT_W + 1);
   localparam logic [FW-1:0] FILL_FULL = FW'(PAT_W);

   typedef enum logic [1:0] {
      EMPTY   = 2'd0,
      FILLING = 2'd1,
      ARMED   = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [PAT_W-1:0]  hist_q, hist_d;
   logic [FW-1:0]     fill_q, fill_d;
   logic [PAT_W-1:0]  pat_q, pat_d;
   logic [PAT_W-1:0]  care_q, care_d;
   logic              z_q, z_d;

   logic              sample;
   logic [PAT_W-1:0]  hist_shift;
   logic [FW-1:0]     fill_inc;
   logic              match;

   // A bit is taken only when qualified and not overridden by a pattern load.
   assign sample     = en & ~load;
   assign hist_shift = {hist_q[PAT_W-2:0], x};
   assign fill_inc   = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + FW'(1);
   assign match      = sample && (fill_inc == FILL_FULL) &&
                       (((hist_shift ^ pat_q) & care_q) == '0);

   // Next-state for history, fill, pattern/mask and the match pulse.
   always_comb begin
      hist_d = hist_q;
      fill_d = fill_q;
      pat_d  = pat_q;
      care_d = care_q;
      z_d    = 1'b0;
      if (load) begin
         pat_d  = pat_in;
         care_d = care_in;
         hist_d = '0;
         fill_d = '0;
      end else if (sample) begin
         hist_d = hist_shift;
         fill_d = fill_inc;
         z_d    = match;
         // Non-overlapping: the next match must be built from fresh bits.
         if (match && !overlap) begin
            fill_d = '0;
         end
      end
   end

   // FSM state follows the fill level: empty, partially filled, or full.
   always_comb begin
      state_d = state_q;
      if (fill_d == '0) begin
         state_d = EMPTY;
      end else if (fill_d == FILL_FULL) begin
         state_d = ARMED;
      end else begin
         state_d = FILLING;
      end
   end

   // State register; reset restores the power-up pattern and an all-ones mask.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q <= EMPTY;
         hist_q  <= '0;
         fill_q  <= '0;
         pat_q   <= PAT_RESET;
         care_q  <= '1;
         z_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         hist_q  <= hist_d;
         fill_q  <= fill_d;
         pat_q   <= pat_d;
         care_q  <= care_d;
         z_q     <= z_d;
      end
   end

   assign Z       = z_q;
   assign state_o = state_q;

`ifdef MATCH_CNT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Saturating count of match pulses; a clear beats a simultaneous match.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_count) begin
         cnt_d = '0;
      end else if (z_d && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Counter register.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign match_count = cnt_q;
`else
   logic unused_clr_count;
   assign unused_clr_count = clr_count;
   assign match_count      = '0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param (default PAT_W=4, CNT_W=8).
// The driver applies one input vector per cycle at the falling edge and
// pushes the hand-computed Z expected after the following rising edge;
// a monitor pops and compares one entry 1 ns after every rising edge.
module tb_seq_detector_param;

   logic       CLK;
   logic       RESET_N;
   logic       en;
   logic       x;
   logic       load;
   logic [3:0] pat_in;
   logic [3:0] care_in;
   logic       overlap;
   logic       clr_count;
   logic       Z;
   logic [7:0] match_count;
   logic [1:0] state_o;

   logic       exp_q[$];
   int         n_tests;
   int         n_fail;

   localparam logic [1:0] S_EMPTY   = 2'd0;
   localparam logic [1:0] S_FILLING = 2'd1;
   localparam logic [1:0] S_ARMED   = 2'd2;

   seq_detector_param #(
      .PAT_W(4), .PAT_RESET(4'b1101), .CNT_W(8)
   ) dut (
      .CLK(CLK), .RESET_N(RESET_N), .en(en), .x(x), .load(load),
      .pat_in(pat_in), .care_in(care_in), .overlap(overlap),
      .clr_count(clr_count), .Z(Z), .match_count(match_count),
      .state_o(state_o)
   );

   // Clock
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Scoreboard monitor: one expected Z per driven cycle
   initial begin
      logic e;
      forever begin
         @(posedge CLK);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if (Z !== e) begin
               n_fail++;
               $display("FAIL z_pulse @%0t: Z=%b expected %b", $time, Z, e);
            end
         end
      end
   end

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp_v);
      n_tests++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp_v);
      end
   endtask

   // One sampled bit
   task automatic bit_in(input logic b, input logic expz);
      @(negedge CLK);
      en = 1'b1; x = b; load = 1'b0;
      exp_q.push_back(expz);
   endtask

   // One cycle with no sample
   task automatic idle(input logic b);
      @(negedge CLK);
      en = 1'b0; x = b; load = 1'b0;
      exp_q.push_back(1'b0);
   endtask

   // Load pattern/mask; x=1 and en=1 must be ignored this cycle
   task automatic load_pat(input logic [3:0] p, input logic [3:0] c);
      @(negedge CLK);
      en = 1'b1; x = 1'b1; load = 1'b1; pat_in = p; care_in = c;
      exp_q.push_back(1'b0);
   endtask

   // Stream n bits MSB first, with per-bit expected Z
   task automatic bits(input logic [15:0] v, input int n, input logic [15:0] z);
      for (int i = n - 1; i >= 0; i--) bit_in(v[i], z[i]);
   endtask

   // State after the last driven edge
   task automatic chk_state(input string name, input logic [1:0] s);
      @(posedge CLK);
      #2;
      check(name, {6'd0, state_o}, {6'd0, s});
   endtask

   // Asynchronous reset pulse in the middle of a low clock phase
   task automatic reset_pulse();
      @(negedge CLK);
      en = 1'b0; load = 1'b0; x = 1'b0; clr_count = 1'b0;
      #1 RESET_N = 1'b0;
      #1;
      check("rst_z", {7'd0, Z}, 8'd0);
      check("rst_state", {6'd0, state_o}, {6'd0, S_EMPTY});
      check("rst_count", match_count, 8'd0);
      #1 RESET_N = 1'b1;
   endtask

   initial begin
      int guard;
      n_tests = 0; n_fail = 0;
      RESET_N = 1'b0; en = 1'b0; x = 1'b0; load = 1'b0;
      pat_in = 4'd0; care_in = 4'd0; overlap = 1'b1; clr_count = 1'b0;
      #12;
      check("reset_z", {7'd0, Z}, 8'd0);
      check("reset_state", {6'd0, state_o}, {6'd0, S_EMPTY});
      check("reset_count", match_count, 8'd0);
      #1 RESET_N = 1'b1;

      // 1: basic 1101
      overlap = 1'b1;
      bits(16'b1101, 4, 16'b0001);
      idle(1'b1);
      chk_state("t1_armed", S_ARMED);

      // 2: 1101101 overlapping then non-overlapping
      reset_pulse();
      overlap = 1'b1;
      bits(16'b1101101, 7, 16'b0001001);
      reset_pulse();
      overlap = 1'b0;
      bits(16'b1101101, 7, 16'b0001000);
      chk_state("t2_filling", S_FILLING);

      // 3: gap with en=0 and x=0 in between
      reset_pulse();
      overlap = 1'b1;
      bits(16'b11, 2, 16'b00);
      idle(1'b0); idle(1'b0); idle(1'b0);
      bits(16'b01, 2, 16'b01);

      // 4: load discards prior bits
      reset_pulse();
      overlap = 1'b0;
      bits(16'b110, 3, 16'b000);
      load_pat(4'b0110, 4'b1111);
      chk_state("t4_load_empty", S_EMPTY);
      bits(16'b0110, 4, 16'b0001);
      bits(16'b1101, 4, 16'b0000);

      // 5: don't-care bit, then reset restores 1101
      load_pat(4'b1001, 4'b1011);
      bits(16'b1001, 4, 16'b0001);
      bits(16'b1101, 4, 16'b0001);
      bits(16'b1000, 4, 16'b0000);
      bits(16'b11, 2, 16'b00);
      reset_pulse();
      overlap = 1'b1;
      bits(16'b1001, 4, 16'b0000);
      bits(16'b1101, 4, 16'b0001);

      // Care mask all zero: every armed sample matches
      load_pat(4'b0000, 4'b0000);
      bits(16'b01010, 5, 16'b00011);

      // 6: saturating counter with 300 overlapping matches
      reset_pulse();
      load_pat(4'b1111, 4'b1111);
      overlap = 1'b1;
      bits(16'b111, 3, 16'b000);
      for (int i = 0; i < 300; i++) bit_in(1'b1, 1'b1);
      @(posedge CLK); #2;
`ifdef MATCH_CNT_EN
      check("count_sat", match_count, 8'd255);
`else
      check("count_off", match_count, 8'd0);
`endif
      @(negedge CLK);
      en = 1'b1; x = 1'b1; load = 1'b0; clr_count = 1'b1;
      exp_q.push_back(1'b1);
      @(posedge CLK); #2;
      check("count_clr", match_count, 8'd0);
      @(negedge CLK);
      clr_count = 1'b0;
      exp_q.push_back(1'b1);
      @(posedge CLK); #2;
`ifdef MATCH_CNT_EN
      check("count_after_clr", match_count, 8'd1);
`else
      check("count_after_clr", match_count, 8'd0);
`endif
      idle(1'b0);

      // Drain the scoreboard with a bounded wait
      guard = 0;
      while (exp_q.size() > 0 && guard < 20) begin
         @(posedge CLK);
         guard++;
      end
      #3;
      if (exp_q.size() > 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
